// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states and byte constants for the PS/2 receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PREFIX_EXT  = 8'hE0;
  localparam logic [7:0] PREFIX_BRK  = 8'hF0;
  localparam logic [7:0] BYTE_ERR0   = 8'h00;
  localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
  localparam logic [7:0] BYTE_ECHO   = 8'hEE;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ERR1   = 8'hFF;

  // Device status/control replies that never denote a key
  function automatic logic is_non_key(input logic [7:0] b);
    return (b == BYTE_ERR0) || (b == BYTE_BAT_OK) || (b == BYTE_ECHO) ||
           (b == BYTE_ACK) || (b == BYTE_RESEND) || (b == BYTE_ERR1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - pin synchronisers and ps2_clk glitch filter
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat_s,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          level;
  logic [CW-1:0] cnt;

  assign dat_s = dat_sync[1];

  // level only follows the synced clock after FILTER_LEN disagreeing samples in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      level    <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fall     <= 1'b0;
      if (clk_sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= clk_sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 device-to-host deframer with E0/F0 key-event decode
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       err_parity,
  output logic       err_frame,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic dat_s;
  logic fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  ps2_state_t    state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_pend, brk_pend;

  logic timeout_hit, frame_ok, frame_par_err, frame_stop_err;

  always_comb begin
    state_next     = state;
    frame_ok       = 1'b0;
    frame_par_err  = 1'b0;
    frame_stop_err = 1'b0;
    timeout_hit    = (state != IDLE) && !fall && (to_cnt == TO_LAST);
    case (state)
      IDLE:    if (fall && !dat_s) state_next = DATA;
      DATA:    if (fall && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (fall) state_next = STOP;
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          // odd parity over data plus parity bit; parity error outranks a bad stop bit
          if (!(^{shift, parity_bit})) frame_par_err  = 1'b1;
          else if (!dat_s)             frame_stop_err = 1'b1;
          else                         frame_ok       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      state      <= state_next;
      byte_valid <= frame_ok;
      err_parity <= frame_par_err;
      err_frame  <= frame_stop_err | timeout_hit;
      if (frame_ok) byte_data <= shift;
      if (fall || state == IDLE)  to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= 3'd0;
          DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  parity_bit <= dat_s;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (err_parity || err_frame) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PREFIX_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_data == PREFIX_BRK) begin
          brk_pend <= 1'b1;
        end else if (!is_non_key(byte_data)) begin
          key_code  <= byte_data;
          key_ext   <= ext_pend;
          key_break <= brk_pend;
          key_valid <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - scoreboard bench for ps2_receiver
module tb_ps2_receiver;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 40;

  localparam logic [2:0] K_BYTE = 3'b100;
  localparam logic [2:0] K_PAR  = 3'b010;
  localparam logic [2:0] K_FRM  = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       err_parity;
  logic       err_frame;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;

  ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .key_valid  (key_valid)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t        ev_q[$];
  logic [9:0] key_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       m_ext    = 1'b0;
  logic       m_brk    = 1'b0;
  logic [7:0] last_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic non_key(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic model_error(input logic [2:0] kind);
    ev_q.push_back('{kind: kind, data: 8'h00});
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic drain(input string tag);
    ps2_dat = 1'b1;
    wait_cyc(2 * HALF);
    check({tag, "_ev_left"}, 32'(ev_q.size()), 32'd0);
    check({tag, "_key_left"}, 32'(key_q.size()), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    if (flip) begin
      model_error(K_PAR);
    end else if (!stop) begin
      model_error(K_FRM);
    end else begin
      ev_q.push_back('{kind: K_BYTE, data: b});
      last_byte = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (!non_key(b)) begin
        key_q.push_back({b, m_ext, m_brk});
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
    send_bits(frame_bits(b, flip, stop), 11);
    drain("frame");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_err_parity"}, 32'(err_parity), 32'd0);
    check({tag, "_err_frame"}, 32'(err_frame), 32'd0);
    check({tag, "_key_code"}, 32'(key_code), 32'd0);
    check({tag, "_key_ext"}, 32'(key_ext), 32'd0);
    check({tag, "_key_break"}, 32'(key_break), 32'd0);
    check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;

    fork
      begin
        logic prev_bv = 1'b0;
        ev_t  e;
        forever begin
          @(negedge clk);
          if (!rst) begin
            if (byte_valid || err_parity || err_frame) begin
              if (ev_q.size() == 0) begin
                check("unexpected_pulse", 32'({byte_valid, err_parity, err_frame}), 32'd0);
              end else begin
                e = ev_q.pop_front();
                check("pulse_kind", 32'({byte_valid, err_parity, err_frame}), 32'(e.kind));
                if (e.kind == K_BYTE) check("byte_data", 32'(byte_data), 32'(e.data));
              end
            end
            if (key_valid) begin
              check("key_latency", 32'(prev_bv), 32'd1);
              if (key_q.size() == 0)
                check("unexpected_key", 32'({key_code, key_ext, key_break}), 32'd0);
              else
                check("key_event", 32'({key_code, key_ext, key_break}), 32'(key_q.pop_front()));
            end
            prev_bv = byte_valid;
          end else begin
            prev_bv = 1'b0;
          end
        end
      end
    join_none

    wait_cyc(5);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(20);

    // single make code
    send_frame(8'h1C, 1'b0, 1'b1);

    // extended break
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);

    // parity error clears a pending break
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);

    // bad stop bit keeps the previous byte
    send_frame(8'h33, 1'b0, 1'b0);
    check("byte_hold", 32'(byte_data), 32'(last_byte));

    // mid-frame timeout clears a pending extension
    send_frame(8'hE0, 1'b0, 1'b1);
    model_error(K_FRM);
    send_bits(frame_bits(8'h5A, 1'b0, 1'b1), 5);
    ps2_dat = 1'b1;
    wait_cyc(3 * TO);
    check("timeout_ev_left", 32'(ev_q.size()), 32'd0);
    check("timeout_byte_hold", 32'(byte_data), 32'(last_byte));
    send_frame(8'h16, 1'b0, 1'b1);

    // short ps2_clk glitch in idle is ignored
    ps2_clk = 1'b0;
    wait_cyc(FL - 2);
    ps2_clk = 1'b1;
    wait_cyc(100);
    send_frame(8'h29, 1'b0, 1'b1);

    // async reset mid-frame drops the partial frame and pending break
    send_frame(8'hF0, 1'b0, 1'b1);
    send_bits(frame_bits(8'h4B, 1'b0, 1'b1), 4);
    wait_cyc(HALF / 2);
    #3 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    m_ext = 1'b0;
    m_brk = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(10);
    rst = 1'b0;
    wait_cyc(20);
    send_frame(8'h1C, 1'b0, 1'b1);

    // non-key bytes leave pending flags alone
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    send_frame(8'h16, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);

    wait_cyc(50);
    check("final_ev_left", 32'(ev_q.size()), 32'd0);
    check("final_key_left", 32'(key_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
